// File: rtl/sc_jug_move_ctrl.sv
// sc_jug_move_ctrl
// Player-movement controller for the road game. Turns the two active-low player keys into a
// 2-bit shift-selection command for the player position register. Moves that would rotate the
// player off the board edge are refused and reported with a one-cycle bump pulse.
//
// Ports:
//   SC_JugCtrl_CLOCK_50              in   system clock, rising edge
//   SC_JugCtrl_RESET_InHigh          in   synchronous active-high reset
//   SC_JugCtrl_left_InLow            in   left key, asynchronous, active-low
//   SC_JugCtrl_right_InLow           in   right key, asynchronous, active-low
//   SC_JugCtrl_position_InBUS        in   current player register contents
//   SC_JugCtrl_shiftselection_OutBUS out  01 = left (toward MSB), 10 = right (toward LSB), 00 = hold
//   SC_JugCtrl_bump_Out              out  one-cycle pulse when a requested move is refused
//
// Build option: define SC_JUGCTRL_AUTOREPEAT_EN to enable hold-to-repeat. Without it every
// press yields exactly one move (or one bump).
module sc_jug_move_ctrl #(
  parameter int unsigned JUGCTRL_DATAWIDTH       = 8,
  parameter int unsigned JUGCTRL_DEBOUNCE_CYCLES = 500000,
  parameter int unsigned JUGCTRL_REPEAT_DELAY    = 25000000,
  parameter int unsigned JUGCTRL_REPEAT_PERIOD   = 5000000,
  parameter int unsigned JUGCTRL_CNT_WIDTH       = 25
) (
  input  logic                         SC_JugCtrl_CLOCK_50,
  input  logic                         SC_JugCtrl_RESET_InHigh,
  input  logic                         SC_JugCtrl_left_InLow,
  input  logic                         SC_JugCtrl_right_InLow,
  input  logic [JUGCTRL_DATAWIDTH-1:0] SC_JugCtrl_position_InBUS,
  output logic [1:0]                   SC_JugCtrl_shiftselection_OutBUS,
  output logic                         SC_JugCtrl_bump_Out
);

  // Elaboration-time guard: every count parameter must fit the counter width.
  if (JUGCTRL_DATAWIDTH == 0 || JUGCTRL_DEBOUNCE_CYCLES == 0 ||
      $clog2(JUGCTRL_DEBOUNCE_CYCLES + 1) > JUGCTRL_CNT_WIDTH ||
      $clog2(JUGCTRL_REPEAT_DELAY + 1) > JUGCTRL_CNT_WIDTH ||
      $clog2(JUGCTRL_REPEAT_PERIOD + 1) > JUGCTRL_CNT_WIDTH) begin : g_bad_params
    $error("sc_jug_move_ctrl: count parameter does not fit JUGCTRL_CNT_WIDTH");
  end

  localparam logic [JUGCTRL_CNT_WIDTH-1:0] LP_DB_LAST =
    JUGCTRL_CNT_WIDTH'(JUGCTRL_DEBOUNCE_CYCLES - 1);
  localparam logic [JUGCTRL_CNT_WIDTH-1:0] LP_ONE = JUGCTRL_CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StHold,
    StRepeat,
    StWaitRel
  } state_t;

  // Index 0 = left key, index 1 = right key. All levels are active-low (1 = released).
  logic [1:0]                   r_sync1;
  logic [1:0]                   r_sync2;
  logic [1:0]                   r_db;
  logic [JUGCTRL_CNT_WIDTH-1:0] r_db_cnt [2];
  logic [1:0]                   r_warm;
  logic                         r_armed;

  state_t                       r_state;
  logic                         r_dir;  // 1 = right, 0 = left
  logic [1:0]                   r_shift;
  logic                         r_bump;

  logic w_left_pr;
  logic w_right_pr;
  logic w_req_left;
  logic w_req_right;
  logic w_legal_left;
  logic w_legal_right;
  logic w_move_legal;
  logic [1:0] w_move_cmd;
`ifdef SC_JUGCTRL_AUTOREPEAT_EN
  logic w_keep;
`endif

  // ---------------------------------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizer, then a debounce counter that counts consecutive cycles
  // in which the synchronized level disagrees with the accepted level. Any cycle of agreement
  // (a bounce back) restarts the count.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge SC_JugCtrl_CLOCK_50) begin
    if (SC_JugCtrl_RESET_InHigh) begin
      r_sync1     <= 2'b11;
      r_sync2     <= 2'b11;
      r_db        <= 2'b11;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_sync1 <= {SC_JugCtrl_right_InLow, SC_JugCtrl_left_InLow};
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == LP_DB_LAST) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + LP_ONE;
        end
      end
      // A key held through reset must be seen released before any request is honoured.
      // r_warm[1] marks that r_sync2 now holds a real pin sample rather than its reset value.
      if (r_warm[1] && (&r_sync2) && (&r_db)) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_left_pr   = ~r_db[0];
  assign w_right_pr  = ~r_db[1];
  assign w_req_left  = w_left_pr & ~w_right_pr;
  assign w_req_right = w_right_pr & ~w_left_pr;

  // An empty board has no player to move, so both directions are refused.
  assign w_legal_left  = ~SC_JugCtrl_position_InBUS[JUGCTRL_DATAWIDTH-1] &
                         (|SC_JugCtrl_position_InBUS);
  assign w_legal_right = ~SC_JugCtrl_position_InBUS[0] & (|SC_JugCtrl_position_InBUS);

  assign w_move_legal = r_dir ? w_legal_right : w_legal_left;
  assign w_move_cmd   = r_dir ? 2'b10 : 2'b01;

`ifdef SC_JUGCTRL_AUTOREPEAT_EN
  localparam logic [JUGCTRL_CNT_WIDTH-1:0] LP_REP_DELAY  = JUGCTRL_CNT_WIDTH'(JUGCTRL_REPEAT_DELAY);
  localparam logic [JUGCTRL_CNT_WIDTH-1:0] LP_REP_PERIOD =
    JUGCTRL_CNT_WIDTH'(JUGCTRL_REPEAT_PERIOD);

  logic [JUGCTRL_CNT_WIDTH-1:0] r_rep_cnt;

  // Same single-direction request still present; both keys pressed drops it.
  assign w_keep = r_dir ? w_req_right : w_req_left;
`endif

  // ---------------------------------------------------------------------------------------------
  // Movement FSM with registered command and bump outputs.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge SC_JugCtrl_CLOCK_50) begin
    if (SC_JugCtrl_RESET_InHigh) begin
      r_state   <= StIdle;
      r_dir     <= 1'b0;
      r_shift   <= 2'b00;
      r_bump    <= 1'b0;
`ifdef SC_JUGCTRL_AUTOREPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_shift <= 2'b00;
      r_bump  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_armed && (w_req_left || w_req_right)) begin
            r_dir   <= w_req_right;
            r_state <= StMove;
          end
        end
        StMove: begin
          if (w_move_legal) r_shift <= w_move_cmd;
          else              r_bump  <= 1'b1;
`ifdef SC_JUGCTRL_AUTOREPEAT_EN
          r_rep_cnt <= LP_REP_DELAY;
          r_state   <= StHold;
`else
          r_state   <= StWaitRel;
`endif
        end
`ifdef SC_JUGCTRL_AUTOREPEAT_EN
        // The HOLD->REPEAT transition itself carries the first repeat move, which places it
        // REPEAT_DELAY+1 cycles after the initial move; later ones land every REPEAT_PERIOD+1.
        StHold, StRepeat: begin
          if (!w_keep) begin
            r_state <= StWaitRel;
          end else if (r_rep_cnt == '0) begin
            if (w_move_legal) r_shift <= w_move_cmd;
            else              r_bump  <= 1'b1;
            r_rep_cnt <= LP_REP_PERIOD;
            r_state   <= StRepeat;
          end else begin
            r_rep_cnt <= r_rep_cnt - LP_ONE;
          end
        end
`endif
        StWaitRel: begin
          if (&r_db) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign SC_JugCtrl_shiftselection_OutBUS = r_shift;
  assign SC_JugCtrl_bump_Out              = r_bump;

endmodule
